// File: rtl/reg_write_tracker_pkg.sv
// Shared pipeline-slot types for the destination/write-enable tracker.
// Provides the slot record, bubble constant and tracker FSM states.
package reg_write_tracker_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/reg_write_tracker_if.sv
// ID-side inputs and MEM/WB/stall outputs of the write tracker.
// master: pipeline control driving ID fields; slave: the tracker.
interface reg_write_tracker_if;
    import reg_write_tracker_pkg::*;

    logic [REG_ADDR_W-1:0] ID_rs;
    logic [REG_ADDR_W-1:0] ID_rt;
    logic [REG_ADDR_W-1:0] ID_rd;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  ID_Mul;
    logic                  flush_i;

    logic [REG_ADDR_W-1:0] EX_rd_o;
    logic [REG_ADDR_W-1:0] MEM_rd;
    logic [REG_ADDR_W-1:0] WB_rd;
    logic                  MEM_RegWrite;
    logic                  WB_RegWrite;
    logic                  PC_write;
    logic                  IFID_write;
    logic                  mul_busy_o;

    modport master (
        output ID_rs, ID_rt, ID_rd,
        output ID_RegWrite, ID_MemRead, ID_Mul,
        output flush_i,
        input  EX_rd_o, MEM_rd, WB_rd,
        input  MEM_RegWrite, WB_RegWrite,
        input  PC_write, IFID_write, mul_busy_o
    );

    modport slave (
        input  ID_rs, ID_rt, ID_rd,
        input  ID_RegWrite, ID_MemRead, ID_Mul,
        input  flush_i,
        output EX_rd_o, MEM_rd, WB_rd,
        output MEM_RegWrite, WB_RegWrite,
        output PC_write, IFID_write, mul_busy_o
    );

endinterface

// File: rtl/reg_write_tracker_hazard_detect.sv
// Combinational load-use detection and PC / IF-ID write enables.
// In: EX rd/MemRead, ID rs/rt, mul_busy. Out: load_use, pc_write, ifid_write.
module reg_write_tracker_hazard_detect
    import reg_write_tracker_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  mul_busy,
    output logic                  load_use,
    output logic                  pc_write,
    output logic                  ifid_write
);

    logic src_hit;

    // r0 is never a real dependency, so a load to r0 cannot stall.
    assign src_hit  = (ex_rd == id_rs) || (ex_rd == id_rt);
    assign load_use = ex_mem_read && (ex_rd != '0) && src_hit;

    assign pc_write   = !(load_use || mul_busy);
    assign ifid_write = !(load_use || mul_busy);

endmodule

// File: rtl/reg_write_tracker.sv
// Tracks rd/RegWrite/MemRead through EX, MEM, WB and raises pipeline stalls.
// Ports: clk_i, rst_n, bus (slave) carrying ID inputs and stage outputs.
module reg_write_tracker
    import reg_write_tracker_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    reg_write_tracker_if.slave   bus
);

    localparam int CNT_W = $clog2(MUL_LAT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    slot_t              ex_q, ex_d;
    slot_t              mem_q, mem_d;
    slot_t              wb_q, wb_d;
    slot_t              id_slot;
    logic               load_use;
    logic               mul_busy;
    logic               pc_write;
    logic               ifid_write;

    assign mul_busy = (state_q == MUL_WAIT);

    reg_write_tracker_hazard_detect u_hazard (
        .ex_rd       (ex_q.rd),
        .ex_mem_read (ex_q.mem_read),
        .id_rs       (bus.ID_rs),
        .id_rt       (bus.ID_rt),
        .mul_busy    (mul_busy),
        .load_use    (load_use),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write)
    );

    always_comb begin
        id_slot.rd        = bus.ID_rd;
        id_slot.reg_write = bus.ID_RegWrite;
        id_slot.mem_read  = bus.ID_MemRead;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        unique case (state_q)
            RUN: begin
                wb_d  = mem_q;
                mem_d = ex_q;
                // flush wins over load_use; both insert one bubble.
                if (bus.flush_i || load_use) begin
                    ex_d = BUBBLE;
                end else begin
                    ex_d = id_slot;
                    if (bus.ID_Mul) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end
            end
            MUL_WAIT: begin
                // Multiply holds EX; downstream drains, flush is ignored
                // because the multiply is older than the branch.
                wb_d  = mem_q;
                mem_d = BUBBLE;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.EX_rd_o      = ex_q.rd;
    assign bus.MEM_rd       = mem_q.rd;
    assign bus.WB_rd        = wb_q.rd;
    assign bus.MEM_RegWrite = mem_q.reg_write;
    assign bus.WB_RegWrite  = wb_q.reg_write;
    assign bus.PC_write     = pc_write;
    assign bus.IFID_write   = ifid_write;
    assign bus.mul_busy_o   = mul_busy;

endmodule

// File: tb/tb_reg_write_tracker.sv
// Scoreboard bench for reg_write_tracker (MUL_LAT = 4).
// Stimulus queues expected per-cycle outputs; a negedge monitor checks them.
module tb_reg_write_tracker;

    localparam int EX_RD  = 0;
    localparam int MEM_RD = 1;
    localparam int WB_RD  = 2;
    localparam int MEM_RW = 3;
    localparam int WB_RW  = 4;
    localparam int PCW    = 5;
    localparam int IFIDW  = 6;
    localparam int BUSY   = 7;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    logic clk_i;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    reg_write_tracker_if bus ();

    reg_write_tracker #(.MUL_LAT(4)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic int actual(int sel);
        case (sel)
            EX_RD:   return int'(bus.EX_rd_o);
            MEM_RD:  return int'(bus.MEM_rd);
            WB_RD:   return int'(bus.WB_rd);
            MEM_RW:  return int'(bus.MEM_RegWrite);
            WB_RW:   return int'(bus.WB_RegWrite);
            PCW:     return int'(bus.PC_write);
            IFIDW:   return int'(bus.IFID_write);
            default: return int'(bus.mul_busy_o);
        endcase
    endfunction

    // Monitor: check every expectation queued for the current cycle.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int   a;
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: stale expectation for cycle %0d at %0d",
                         e.name, e.cyc, cyc);
            end else begin
                a = actual(e.sel);
                if (a != e.val) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d got %0d want %0d",
                             e.name, cyc, a, e.val);
                end
            end
        end
    end

    task automatic chk(int sel, int val, string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        bus.ID_rs       = '0;
        bus.ID_rt       = '0;
        bus.ID_rd       = '0;
        bus.ID_RegWrite = 1'b0;
        bus.ID_MemRead  = 1'b0;
        bus.ID_Mul      = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic set_id(int rs, int rt, int rd, bit rw, bit mr, bit mul);
        bus.ID_rs       = 5'(rs);
        bus.ID_rt       = 5'(rt);
        bus.ID_rd       = 5'(rd);
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.ID_Mul      = mul;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clr();

        // Reset state
        step();
        chk(EX_RD, 0, "rst_ex_rd");
        chk(MEM_RD, 0, "rst_mem_rd");
        chk(WB_RD, 0, "rst_wb_rd");
        chk(MEM_RW, 0, "rst_mem_rw");
        chk(WB_RW, 0, "rst_wb_rw");
        chk(PCW, 1, "rst_pc_write");
        chk(IFIDW, 1, "rst_ifid_write");
        chk(BUSY, 0, "rst_busy");
        rst_n = 1'b1;
        step();

        // Plain flow: rd=5 through EX, MEM, WB
        set_id(1, 2, 5, 1, 0, 0);
        chk(PCW, 1, "flow_pc_write");
        step();
        clr();
        chk(EX_RD, 5, "flow_ex_rd");
        step();
        chk(MEM_RD, 5, "flow_mem_rd");
        chk(MEM_RW, 1, "flow_mem_rw");
        step();
        chk(WB_RD, 5, "flow_wb_rd");
        chk(WB_RW, 1, "flow_wb_rw");
        step();

        // Load-use on rs: lw rd=8, then user rs=8 rd=3
        set_id(0, 0, 8, 1, 1, 0);
        step();
        set_id(8, 1, 3, 1, 0, 0);
        chk(EX_RD, 8, "lu_ex_lw");
        chk(PCW, 0, "lu_pc_write");
        chk(IFIDW, 0, "lu_ifid_write");
        step();
        chk(EX_RD, 0, "lu_ex_bubble");
        chk(MEM_RD, 8, "lu_mem_lw");
        chk(PCW, 1, "lu_pc_release");
        step();
        clr();
        chk(EX_RD, 3, "lu_ex_user");
        chk(MEM_RD, 0, "lu_mem_bubble");
        chk(WB_RD, 8, "lu_wb_lw");
        step();

        // Load to r0 never stalls
        set_id(0, 0, 0, 1, 1, 0);
        step();
        set_id(0, 0, 4, 1, 0, 0);
        chk(PCW, 1, "lu0_pc_write");
        chk(IFIDW, 1, "lu0_ifid_write");
        step();
        clr();
        chk(EX_RD, 4, "lu0_ex_rd");
        step();
        step();

        // Multiply rd=12, then rd=7 waiting in ID
        set_id(0, 0, 12, 1, 0, 1);
        chk(BUSY, 0, "mul_busy_pre");
        step();
        set_id(0, 0, 7, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk(BUSY, 1, "mul_busy_hold");
            chk(EX_RD, 12, "mul_ex_hold");
            chk(MEM_RD, 0, "mul_mem_hold");
            chk(PCW, 0, "mul_pc_hold");
            step();
        end
        chk(BUSY, 0, "mul_busy_done");
        chk(EX_RD, 12, "mul_ex_last");
        chk(PCW, 1, "mul_pc_release");
        step();
        clr();
        chk(MEM_RD, 12, "mul_mem_rd");
        chk(MEM_RW, 1, "mul_mem_rw");
        chk(EX_RD, 7, "mul_ex_next");
        step();
        step();

        // Flush in RUN
        set_id(0, 0, 9, 1, 0, 0);
        bus.flush_i = 1'b1;
        step();
        clr();
        chk(EX_RD, 0, "flush_ex_rd");
        step();
        chk(MEM_RD, 0, "flush_mem_rd");
        chk(MEM_RW, 0, "flush_mem_rw");
        step();

        // Flush ignored during MUL_WAIT
        set_id(0, 0, 13, 1, 0, 1);
        step();
        clr();
        bus.flush_i = 1'b1;
        chk(BUSY, 1, "mflush_busy");
        step();
        chk(EX_RD, 13, "mflush_ex_hold");
        step();
        step();
        bus.flush_i = 1'b0;
        chk(EX_RD, 13, "mflush_ex_last");
        step();
        chk(MEM_RD, 13, "mflush_mem_rd");
        chk(MEM_RW, 1, "mflush_mem_rw");
        step();
        step();

        // Flush together with load-use: one bubble, one stall cycle
        set_id(0, 0, 10, 1, 1, 0);
        step();
        set_id(10, 0, 6, 1, 0, 0);
        bus.flush_i = 1'b1;
        chk(PCW, 0, "fl_lu_pc_write");
        step();
        bus.flush_i = 1'b0;
        chk(EX_RD, 0, "fl_lu_ex_bubble");
        chk(PCW, 1, "fl_lu_pc_release");
        step();
        clr();
        chk(EX_RD, 6, "fl_lu_ex_user");
        step();
        step();

        // Asynchronous reset in the middle of a multiply
        set_id(0, 0, 14, 1, 0, 1);
        step();
        clr();
        chk(BUSY, 1, "rmul_busy");
        step();
        rst_n = 1'b0;
        #1;
        chk(BUSY, 0, "rmul_busy_rst");
        chk(EX_RD, 0, "rmul_ex_rst");
        chk(MEM_RD, 0, "rmul_mem_rst");
        chk(WB_RD, 0, "rmul_wb_rst");
        chk(PCW, 1, "rmul_pc_rst");
        step();
        rst_n = 1'b1;
        step();
        chk(BUSY, 0, "rmul_busy_after");
        chk(EX_RD, 0, "rmul_ex_after");

        // Drain remaining expectations, bounded
        for (int i = 0; i < 5 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_tracker.md
# reg_write_tracker

Producer-side companion to the EX-stage forwarding unit: tracks the destination register and write-enable of every in-flight instruction through the ID/EX, EX/MEM and MEM/WB boundaries. It publishes the MEM-stage and WB-stage destination/RegWrite pairs that forwarding consumes. It also generates the pipeline stalls forwarding cannot hide: load-use hazards and multi-cycle multiply occupancy of EX. It sits beside the pipeline registers in each core and replaces their ad-hoc rd/RegWrite fields.

## Interface
- MUL_LAT, 4, EX cycles a multiply occupies (legal range 2..16)
- clk_i  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ID_rs, ID_rt  in  5  source registers of the instruction in ID
- ID_rd  in  5  resolved destination of the instruction in ID
- ID_RegWrite, ID_MemRead, ID_Mul  in  1  control bits of the ID instruction
- flush_i  in  1  squash the instruction entering EX (branch taken)
- EX_rd_o  out  5  destination held in EX
- MEM_rd, WB_rd  out  5  destinations held in MEM and WB (to forwarding)
- MEM_RegWrite, WB_RegWrite  out  1  write enables held in MEM and WB (to forwarding)
- PC_write, IFID_write  out  1  low = hold PC / IF-ID register this cycle
- mul_busy_o  out  1  EX is occupied by a multiply that is not yet finished

## Operation
- Three slots (EX, MEM, WB), each holding {rd[4:0], RegWrite, MemRead}; a bubble is {0,0,0}.
- State machine with two states: RUN and MUL_WAIT; down-counter cnt, $clog2(MUL_LAT) bits.
- load_use = EX.MemRead & (EX.rd != 0) & ((EX.rd == ID_rs) | (EX.rd == ID_rt)); combinational.
- RUN, per edge: WB←MEM, MEM←EX; EX←bubble if flush_i or load_use, else {ID_rd, ID_RegWrite, ID_MemRead}.
- RUN, ID_Mul accepted into EX (not flushed, no load_use): next state MUL_WAIT, cnt←MUL_LAT-1.
- MUL_WAIT, per edge: EX holds; MEM←bubble; WB←MEM; cnt←cnt-1. When cnt==1, the next state is RUN. The multiply then advances to MEM on the following edge.
- flush_i is ignored while in MUL_WAIT: the multiply in EX is older than the branch; the IF/ID squash is handled upstream.
- Priority when advancing EX: flush_i > load_use > normal capture.
- PC_write = IFID_write = !(load_use | mul_busy_o); mul_busy_o = (state == MUL_WAIT).
- An ID_rd of 0 is captured as-is; forwarding ignores rd 0, and load_use ignores EX.rd 0.

## Timing
- Reset (asynchronous, rst_n low): all slots bubble, state RUN, cnt 0. All rd outputs and RegWrite outputs are 0; mul_busy_o is 0; PC_write and IFID_write are 1.
- Slot outputs are registered: an instruction visible in ID at cycle n appears on EX_rd_o at n+1, MEM_rd at n+2 and WB_rd at n+3 when no stall occurs.
- A load-use hazard stalls for exactly 1 cycle. PC_write and IFID_write are low in the same cycle as the hazard, combinationally from the EX slot and the ID inputs.
- A multiply holds EX for MUL_LAT cycles total: mul_busy_o is high for MUL_LAT-1 cycles starting the cycle after capture.
- Load-use during MUL_WAIT has no additional effect; the stall is already asserted.
- If rst_n is asserted mid-multiply, the multiply is abandoned immediately and the block returns to the reset state.

## Structure
- Shared package (core-wide): slot record typedef {rd, RegWrite, MemRead}, BUBBLE constant, state enum {RUN, MUL_WAIT}, REG_ADDR_W = 5.
- One sub-module, hazard_detect: purely combinational load_use and the PC_write/IFID_write derivation. All slots, the FSM and cnt stay in the top.

## Test plan
- Reset then release: all rd outputs and RegWrite outputs are 0 and PC_write=1. Then present ID_rd=5 with RegWrite=1 for one cycle → MEM_rd=5 with MEM_RegWrite=1 two cycles later, and WB_rd=5 with WB_RegWrite=1 three cycles later.
- Load-use: lw to rd=8, followed by an ID instruction with rs=8 → PC_write=IFID_write=0 for 1 cycle, and EX_rd_o=0 on the next edge. Repeat with rd=0 → no stall.
- Multiply with MUL_LAT=4 and rd=12: mul_busy_o is high for 3 cycles and EX_rd_o stays 12. MEM_rd=0 during the hold, and MEM_rd=12 on the edge after mul_busy_o falls.
- Branch flush: flush_i=1 with ID_rd=9 in RUN → EX_rd_o=0. flush_i=1 asserted during MUL_WAIT → the multiply still completes and reaches MEM_rd.
- Simultaneous flush_i and load_use → a single bubble enters EX and the stall lasts 1 cycle. Pull rst_n low mid-MUL_WAIT → mul_busy_o drops to 0 and all slot outputs are 0 asynchronously.
